dlf_op_dispatch: RTL

Front-end issue controller for the DL-Float datapath. It accepts one operation request at a time: a 3-bit opcode plus three 16-bit DLFloat operands. It registers the operands, pulses the start of the selected functional unit, and waits for that unit's done. It then drives the select and result-valid timing that the registered result mux at the back end consumes.

---
 rtl/dlf_pkg.sv | 23 ++
 rtl/dlf_dispatch_timer.sv | 29 ++
 rtl/dlf_op_dispatch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dlf_pkg.sv
// Shared definitions for the DL-Float issue front end: operand width,
// opcode numbering and the dispatcher state encoding.
package dlf_pkg;

    localparam int DLF_W = 16;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_MAC  = 3'd4;
    localparam logic [2:0] OP_SQRT = 3'd5;
    localparam logic [2:0] OP_NORM = 3'd6;
    localparam logic [2:0] OP_DP   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/dlf_dispatch_timer.sv
// Clearable 8-bit up-counter for the WAIT watchdog; tc flags that the count
// has reached TIMEOUT-1. The dispatcher never enables it past tc.
module dlf_dispatch_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] TC_VALUE = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == TC_VALUE);

endmodule

// File: rtl/dlf_op_dispatch.sv
// Issue controller for the DL-Float units: registers one request, pulses the
// unit start, waits for its done and times the result-mux valid.
// Optional DLF_DISPATCH_SKID_EN adds a one-entry skid so a request can queue while busy.
module dlf_op_dispatch
    import dlf_pkg::*;
#(
    parameter int DATA_W  = DLF_W,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [DATA_W-1:0]       in_a,
    input  logic [DATA_W-1:0]       in_b,
    input  logic [DATA_W-1:0]       in_c,
    output logic [DATA_W-1:0]       op_a,
    output logic [DATA_W-1:0]       op_b,
    output logic [DATA_W-1:0]       op_c,
    output logic [(1<<SEL_W)-1:0]   unit_start,
    input  logic [(1<<SEL_W)-1:0]   unit_done,
    output logic [SEL_W-1:0]        mux_sel,
    output logic                    res_valid,
    output logic                    busy,
    output logic                    timeout_err
);

    state_t state, next_state;

    logic                  handshake, sel_done, tc, abort, load_in, drain;
    logic                  skid_valid;
    logic [SEL_W-1:0]      skid_sel, next_sel;
    logic [DATA_W-1:0]     skid_a, skid_b, skid_c;
    logic [(1<<SEL_W)-1:0] unit_start_nxt;
    logic                  res_valid_nxt;

    assign handshake = in_valid && in_ready;
    assign load_in   = handshake && (state == IDLE);
    assign sel_done  = (state == WAIT) && unit_done[mux_sel];
    assign abort     = (state == WAIT) && !unit_done[mux_sel] && tc;
    assign drain     = skid_valid && ((state == RESP) || abort);
    assign busy      = (state != IDLE);

`ifdef DLF_DISPATCH_SKID_EN
    // The skid only fills while busy; in IDLE a request goes straight to ISSUE.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            skid_valid <= 1'b0;
            skid_sel   <= '0;
            skid_a     <= '0;
            skid_b     <= '0;
            skid_c     <= '0;
        end else if (handshake && (state != IDLE)) begin
            skid_valid <= 1'b1;
            skid_sel   <= in_sel;
            skid_a     <= in_a;
            skid_b     <= in_b;
            skid_c     <= in_c;
        end else if (drain) begin
            skid_valid <= 1'b0;
        end
    end
`else
    assign in_ready   = (state == IDLE);
    assign skid_valid = 1'b0;
    assign skid_sel   = '0;
    assign skid_a     = '0;
    assign skid_b     = '0;
    assign skid_c     = '0;
`endif

    dlf_dispatch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ISSUE),
        .enable ((state == WAIT) && !unit_done[mux_sel] && !tc),
        .tc     (tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (handshake) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT: begin
                if (sel_done) begin
                    next_state = RESP;
                end else if (abort) begin
                    next_state = skid_valid ? ISSUE : IDLE;
                end
            end
            RESP:    next_state = skid_valid ? ISSUE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Start and valid are computed one cycle ahead so both leave flops.
    always_comb begin
        next_sel = mux_sel;
        if (load_in) begin
            next_sel = in_sel;
        end else if (drain) begin
            next_sel = skid_sel;
        end
        unit_start_nxt = '0;
        if (next_state == ISSUE) begin
            unit_start_nxt[next_sel] = 1'b1;
        end
        res_valid_nxt = (next_state == RESP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_a        <= '0;
            op_b        <= '0;
            op_c        <= '0;
            mux_sel     <= '0;
            unit_start  <= '0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (load_in) begin
                op_a <= in_a;
                op_b <= in_b;
                op_c <= in_c;
            end else if (drain) begin
                op_a <= skid_a;
                op_b <= skid_b;
                op_c <= skid_c;
            end
            mux_sel    <= next_sel;
            unit_start <= unit_start_nxt;
            res_valid  <= res_valid_nxt;
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
